// File: rtl/sat_narrow_pkg.sv
// Shared types, destination bounds and range helpers for the saturating narrowing converter.
package sat_narrow_pkg;

    typedef struct packed {
        logic src_signed;
        logic dst_signed;
        logic dst_w16;
        logic saturate;
    } narrow_mode_t;

    localparam logic signed [32:0] S8_MIN  = -33'sd128;
    localparam logic signed [32:0] S8_MAX  = 33'sd127;
    localparam logic signed [32:0] U8_MAX  = 33'sd255;
    localparam logic signed [32:0] S16_MIN = -33'sd32768;
    localparam logic signed [32:0] S16_MAX = 33'sd32767;
    localparam logic signed [32:0] U16_MAX = 33'sd65535;
    localparam logic signed [32:0] U_MIN   = 33'sd0;

    // True 33-bit value: unsigned 0x80000000 must compare as +2^31.
    function automatic logic signed [32:0] extend_src(input logic [31:0] data,
                                                      input logic        src_signed);
        return $signed({src_signed & data[31], data});
    endfunction

    function automatic logic signed [32:0] dst_min(input narrow_mode_t mode);
        if (!mode.dst_signed) return U_MIN;
        return mode.dst_w16 ? S16_MIN : S8_MIN;
    endfunction

    function automatic logic signed [32:0] dst_max(input narrow_mode_t mode);
        if (mode.dst_signed) return mode.dst_w16 ? S16_MAX : S8_MAX;
        return mode.dst_w16 ? U16_MAX : U8_MAX;
    endfunction

endpackage

// File: rtl/sat_narrow_clamp.sv
// Combinational clamp/wrap stage: turns a registered word plus its range flags into the
// 16-bit narrow result and the overflow flag.
module sat_narrow_clamp
    import sat_narrow_pkg::*;
(
    input  logic [15:0]  value,
    input  narrow_mode_t mode,
    input  logic         below_min,
    input  logic         above_max,
    output logic [15:0]  result,
    output logic         ovf
);

    logic signed [32:0] lo_bound;
    logic signed [32:0] hi_bound;
    logic [15:0]        raw;
    logic               unused_src_signed;

    assign lo_bound          = dst_min(mode);
    assign hi_bound          = dst_max(mode);
    assign unused_src_signed = mode.src_signed;

    always_comb begin
        raw = value;
        if (mode.saturate && below_min) begin
            raw = lo_bound[15:0];
        end else if (mode.saturate && above_max) begin
            raw = hi_bound[15:0];
        end
    end

    // 8-bit results are widened according to the destination signedness.
    assign result = mode.dst_w16 ? raw
                                 : {(mode.dst_signed ? {8{raw[7]}} : 8'h00), raw[7:0]};
    assign ovf    = below_min | above_max;

endmodule

// File: rtl/sat_narrow_converter.sv
// Two-stage valid/ready narrowing converter (32-bit -> 8/16-bit, saturate or wrap).
// Define SAT_NARROW_OVF_CNT_EN to build the overflow counter and ovf_clear logic.
module sat_narrow_converter
    import sat_narrow_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_src_signed,
    input  logic             in_dst_signed,
    input  logic             in_dst_w16,
    input  logic             in_saturate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_ovf,
    input  logic             ovf_clear,
    output logic [CNT_W-1:0] ovf_count
);

    narrow_mode_t       in_mode;
    logic signed [32:0] in_value;
    logic               in_below;
    logic               in_above;

    logic               s1_valid_q, s1_valid_d;
    logic [15:0]        s1_data_q, s1_data_d;
    narrow_mode_t       s1_mode_q, s1_mode_d;
    logic               s1_below_q, s1_below_d;
    logic               s1_above_q, s1_above_d;

    logic               s2_valid_q, s2_valid_d;
    logic [15:0]        s2_data_q, s2_data_d;
    logic               s2_ovf_q, s2_ovf_d;

    logic               s2_ready;
    logic [15:0]        clamp_result;
    logic               clamp_ovf;

    assign in_mode  = '{src_signed: in_src_signed, dst_signed: in_dst_signed,
                        dst_w16: in_dst_w16, saturate: in_saturate};
    assign in_value = extend_src(in_data, in_src_signed);
    assign in_below = in_value < dst_min(in_mode);
    assign in_above = in_value > dst_max(in_mode);

    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !rst && (!s1_valid_q || s2_ready);

    // The range flags summarise the upper word bits, so S1 keeps only the low half.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_below_d = s1_below_q;
        s1_above_d = s1_above_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;
        if (!s1_valid_q || s2_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d  = in_data[15:0];
                s1_mode_d  = in_mode;
                s1_below_d = in_below;
                s1_above_d = in_above;
            end
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = clamp_result;
                s2_ovf_d  = clamp_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= '0;
            s1_below_q <= 1'b0;
            s1_above_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_below_q <= s1_below_d;
            s1_above_q <= s1_above_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    sat_narrow_clamp u_clamp (
        .value     (s1_data_q),
        .mode      (s1_mode_q),
        .below_min (s1_below_q),
        .above_max (s1_above_q),
        .result    (clamp_result),
        .ovf       (clamp_ovf)
    );

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_ovf   = s2_ovf_q;

`ifdef SAT_NARROW_OVF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    // Clear wins over a coincident increment; the count sticks at its maximum.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_clear) begin
            ovf_count_d = '0;
        end else if (out_valid && out_ready && out_ovf && (ovf_count_q != CNT_MAX)) begin
            ovf_count_d = ovf_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`else
    logic unused_ovf_clear;

    assign unused_ovf_clear = ovf_clear;
    assign ovf_count        = '0;
`endif

endmodule

// File: tb/tb_sat_narrow_converter.sv
// Randomised plus directed bench for sat_narrow_converter with a queue-based reference model.
module tb_sat_narrow_converter;

`ifdef SAT_NARROW_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_src_signed, in_dst_signed, in_dst_w16, in_saturate;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        ovf_clear;
    logic [15:0] ovf_count16;
    logic [1:0]  ovf_count2;

    logic        out_valid_b, in_ready_b, out_ovf_b;
    logic [15:0] out_data_b;

    always #5 clk = ~clk;

    sat_narrow_converter #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_src_signed(in_src_signed), .in_dst_signed(in_dst_signed), .in_dst_w16(in_dst_w16),
        .in_saturate(in_saturate), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .ovf_clear(ovf_clear), .ovf_count(ovf_count16)
    );

    sat_narrow_converter #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_src_signed(in_src_signed), .in_dst_signed(in_dst_signed), .in_dst_w16(in_dst_w16),
        .in_saturate(in_saturate), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ovf(out_ovf_b), .ovf_clear(ovf_clear), .ovf_count(ovf_count2)
    );

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   cnt16_m = 0;
    int   cnt2_m = 0;
    bit   check_lat = 1'b0;
    bit   last_acc;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Reference: plain integer arithmetic on the true source value.
    function automatic exp_t model(input logic [31:0] d, input bit ss, input bit ds,
                                   input bit w16, input bit sat);
        exp_t        e;
        longint      v, lo, hi, r;
        logic [63:0] rb;
        v  = ss ? longint'($signed(d)) : longint'(d);
        lo = ds ? (w16 ? -32768 : -128) : 0;
        hi = ds ? (w16 ? 32767 : 127) : (w16 ? 65535 : 255);
        e.ovf = (v < lo) || (v > hi);
        if (sat) r = (v < lo) ? lo : ((v > hi) ? hi : v);
        else     r = v;
        rb = r;
        if (w16)     e.data = rb[15:0];
        else if (ds) e.data = {{8{rb[7]}}, rb[7:0]};
        else         e.data = {8'h00, rb[7:0]};
        e.cyc = 0;
        return e;
    endfunction

    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit ss, input bit ds,
                                 input bit w16, input bit sat, input bit ordy, input bit clr);
        bit   acc, ofire, fire_ovf;
        exp_t e;
        in_valid      = v;
        in_data       = d;
        in_src_signed = ss;
        in_dst_signed = ds;
        in_dst_w16    = w16;
        in_saturate   = sat;
        out_ready     = ordy;
        ovf_clear     = clr;
        #1;
        acc      = in_valid && in_ready;
        ofire    = out_valid && out_ready;
        fire_ovf = 1'b0;
        if (!rst) begin
            checkOutput("ovf_count", {16'h0, ovf_count16}, cnt16_m);
            checkOutput("ovf_count_w2", {30'h0, ovf_count2}, cnt2_m);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", {31'h0, out_valid}, 0);
                end else begin
                    checkOutput("out_data", {16'h0, out_data}, {16'h0, sb[0].data});
                    checkOutput("out_ovf", {31'h0, out_ovf}, {31'h0, sb[0].ovf});
                    if (ofire) begin
                        fire_ovf = sb[0].ovf;
                        if (check_lat) checkOutput("latency", cycle - sb[0].cyc, 2);
                        void'(sb.pop_front());
                    end
                end
            end
            if (acc) begin
                e     = model(d, ss, ds, w16, sat);
                e.cyc = cycle;
                sb.push_back(e);
            end
        end
        last_acc = acc && !rst;
        @(posedge clk);
        cycle++;
        if (rst || !CNT_EN || clr) begin
            cnt16_m = 0;
            cnt2_m  = 0;
        end else if (ofire && fire_ovf) begin
            if (cnt16_m < 65535) cnt16_m++;
            if (cnt2_m < 3) cnt2_m++;
        end
        if (rst) sb.delete();
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy, input bit clr);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, ordy, clr);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1'b1, 1'b0);
        checkOutput("drain_empty", sb.size(), 0);
    endtask

    typedef struct {
        logic [31:0] d;
        bit ss, ds, w16, sat;
    } vec_t;

    vec_t dir_vecs[$];
    vec_t stall_vecs[$];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        logic [31:0] rd;
        rst = 1'b1;
        @(negedge clk);
        idle(1'b0, 1'b0);
        #1;
        checkOutput("rst_in_ready", {31'h0, in_ready}, 0);
        checkOutput("rst_out_valid", {31'h0, out_valid}, 0);
        checkOutput("rst_out_data", {16'h0, out_data}, 0);
        checkOutput("rst_out_ovf", {31'h0, out_ovf}, 0);
        checkOutput("rst_ovf_count", {16'h0, ovf_count16}, 0);
        idle(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", {31'h0, in_ready}, 1);

        // Directed conversions from the plan, free-flowing output.
        $display("[TB] directed conversions");
        dir_vecs = '{
            '{32'hFFFFFF80, 1, 1, 0, 1}, '{32'h000000FF, 0, 0, 0, 1},
            '{32'h00000100, 1, 0, 0, 1}, '{32'h00000100, 1, 0, 0, 0},
            '{32'h80000000, 0, 1, 1, 1}, '{32'h80000000, 1, 1, 1, 1},
            '{32'hFFFFFFFF, 1, 0, 1, 1}, '{32'hFFFFFFFF, 1, 0, 1, 0},
            '{32'hFFFFFFFF, 1, 1, 0, 0}, '{32'h00007FFF, 1, 1, 1, 1},
            '{32'h0000FFFF, 0, 0, 1, 1}, '{32'h00010000, 0, 0, 1, 0}
        };
        check_lat = 1'b1;
        foreach (dir_vecs[i])
            applyStimulus(1'b1, dir_vecs[i].d, dir_vecs[i].ss, dir_vecs[i].ds,
                          dir_vecs[i].w16, dir_vecs[i].sat, 1'b1, 1'b0);
        drain();
        check_lat = 1'b0;

        // Backpressure: 5 stalled cycles offering 3 words.
        $display("[TB] backpressure");
        stall_vecs = '{'{32'h00000123, 1, 0, 0, 1}, '{32'hFFFF8000, 1, 1, 1, 0},
                       '{32'h00000042, 0, 1, 0, 1}};
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(idx < 3, stall_vecs[idx < 3 ? idx : 2].d, stall_vecs[idx < 3 ? idx : 2].ss,
                          stall_vecs[idx < 3 ? idx : 2].ds, stall_vecs[idx < 3 ? idx : 2].w16,
                          stall_vecs[idx < 3 ? idx : 2].sat, 1'b0, 1'b0);
            if (last_acc) idx++;
        end
        checkOutput("stall_accepted", idx, 2);
        in_valid = 1'b1;
        #1;
        checkOutput("stall_in_ready", {31'h0, in_ready}, 0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("release_valid", {31'h0, out_valid}, 1);
            applyStimulus(idx < 3, stall_vecs[2].d, stall_vecs[2].ss, stall_vecs[2].ds,
                          stall_vecs[2].w16, stall_vecs[2].sat, 1'b1, 1'b0);
            if (last_acc) idx++;
        end
        checkOutput("release_accepted", idx, 3);
        drain();

        // Reset in the middle of a stall must flush both stages.
        $display("[TB] reset mid-stall");
        applyStimulus(1'b1, 32'h00000200, 1, 0, 0, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00000300, 1, 1, 0, 1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        rst = 1'b1;
        idle(1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("rst_flush_valid", {31'h0, out_valid}, 0);
        for (int c = 0; c < 4; c++) idle(1'b1, 1'b0);

        // Overflow counter: 3 overflows, clear racing a 4th, then 5 more.
        $display("[TB] overflow counter");
        idle(1'b1, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 32'h00000100, 1, 0, 0, 1, 1'b1, 1'b0);
        drain();
        checkOutput("cnt_three", {16'h0, ovf_count16}, CNT_EN ? 3 : 0);
        applyStimulus(1'b1, 32'h00000100, 1, 0, 0, 1, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        checkOutput("cnt_clear_fire", {31'h0, out_valid && out_ovf}, 1);
        idle(1'b1, 1'b1);
        checkOutput("cnt_clear_prio", {16'h0, ovf_count16}, 0);
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 32'h80000000, 0, 1, 1, 0, 1'b1, 1'b0);
        drain();
        checkOutput("cnt_five", {16'h0, ovf_count16}, CNT_EN ? 5 : 0);
        checkOutput("cnt_w2_sat", {30'h0, ovf_count2}, CNT_EN ? 3 : 0);

        // Random traffic with random backpressure and occasional clears.
        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       rd = $urandom();
                1:       rd = $urandom_range(0, 511) - 256;
                2:       rd = $urandom_range(0, 131071) - 65536;
                default: rd = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom())};
            endcase
            applyStimulus($urandom_range(0, 3) != 0, rd, 1'($urandom()), 1'($urandom()),
                          1'($urandom()), 1'($urandom()), $urandom_range(0, 9) < 7,
                          $urandom_range(0, 49) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sat_narrow_converter.md
# sat_narrow_converter

Streaming narrowing converter: takes 32-bit words, each tagged as signed or unsigned, and converts them to 8-bit or 16-bit signed or unsigned results. Out-of-range values are either saturated or wrapped, and each result is flagged for overflow. It is the inverse companion of the widening signed/unsigned conversion logic: it sits on the return path, after 32-bit arithmetic and before narrow storage or output. A two-stage valid/ready pipeline gives full throughput with backpressure.

## Interface
Parameters:
- CNT_W, 16, width of the overflow counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word offered
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_data  in  32  source value
- in_src_signed  in  1  1: in_data is two's-complement; 0: in_data is unsigned
- in_dst_signed  in  1  1: destination is signed; 0: destination is unsigned
- in_dst_w16  in  1  1: 16-bit destination; 0: 8-bit destination
- in_saturate  in  1  1: clamp to the destination range; 0: truncate (wrap)
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  16  result; an 8-bit result is extended to 16 bits per in_dst_signed
- out_ovf  out  1  source value was outside the destination range
- ovf_clear  in  1  synchronous clear of ovf_count
- ovf_count  out  CNT_W  count of overflowing results delivered

## Operation
- Destination ranges:
  - s8: [-128, 127]
  - u8: [0, 255]
  - s16: [-32768, 32767]
  - u16: [0, 65535]
- Comparison uses the true 33-bit value: the source is sign-extended if in_src_signed, zero-extended otherwise.
  - Unsigned 0x80000000 is +2^31, not negative.
- out_ovf = 1 iff the value lies outside the destination range. The flag is set in both saturate and wrap modes.
- Saturate mode: clamp to the nearest bound. An in-range value passes through unchanged.
- Wrap mode: take the low 8 or 16 bits of in_data.
- 8-bit results:
  - out_data[15:8] = {8{out_data[7]}} if in_dst_signed.
  - out_data[15:8] = 0x00 otherwise.
- The mode bits are sampled with the word. Each word carries its own mode, so modes may change on every beat.
- Pipeline:
  - S1 registers the word, its mode and the range-comparison results.
  - S2 registers out_data and out_ovf.
  - Each stage holds a valid bit. A stage loads when it is empty or when its content moves on this cycle.
- in_ready = !s1_valid || !s2_valid || out_ready. This is a combinational path from out_ready.
- Under backpressure the pipeline holds at most 2 words. Order is preserved, with no loss and no duplication.
- ovf_count:
  - Increments by 1 on each output handshake with out_ovf = 1.
  - Saturates at 2^CNT_W-1.
  - ovf_clear has priority: if it coincides with an increment, the count is 0 on the next cycle and that increment is dropped.

## Timing
- Latency: a word accepted in cycle N appears with out_valid high in cycle N+2, provided the pipeline is not stalled.
- Throughput: 1 word per cycle while out_ready = 1.
- out_valid, out_data and out_ovf are held stable while out_valid && !out_ready.
- Reset values:
  - out_valid = 0, out_data = 0x0000, out_ovf = 0, ovf_count = 0, both stage valid bits = 0.
  - in_ready = 0 while rst = 1, and 1 in the first cycle after reset.
- Reset mid-operation flushes both stages. In-flight words are dropped and never emitted.
- ovf_count updates in the cycle after the handshake that causes the increment.

## Configuration
- SAT_NARROW_OVF_CNT_EN defined:
  - The counter and ovf_clear logic are compiled in, as described above.
- SAT_NARROW_OVF_CNT_EN undefined:
  - No counter register is built and ovf_count is tied to 0.
  - ovf_clear is ignored.
  - out_ovf and all datapath behaviour are unchanged.

## Structure
- sat_narrow_pkg contains:
  - typedef struct packed {src_signed, dst_signed, dst_w16, saturate} narrow_mode_t
  - bound constants S8_MIN/MAX, U8_MAX, S16_MIN/MAX, U16_MAX, as 33-bit signed values
- Sub-module sat_narrow_clamp: purely combinational. It maps {value, narrow_mode_t} to {result[15:0], ovf}. The top level holds the pipeline registers and the counter and instantiates sat_narrow_clamp between S1 and S2.

## Test plan
- Signed in_data 0xFFFFFF80, s8, saturate -> out_data 0xFF80, out_ovf 0; unsigned 0x000000FF, u8 -> 0x00FF, ovf 0.
- Signed 0x00000100, u8: saturate -> 0x00FF, ovf 1; wrap -> 0x0000, ovf 1.
- Unsigned 0x80000000, s16: saturate -> 0x7FFF, ovf 1; signed 0x80000000, s16, saturate -> 0x8000, ovf 1.
- Signed 0xFFFFFFFF, u16: saturate -> 0x0000, ovf 1; wrap -> 0xFFFF, ovf 1; s8 wrap -> 0xFFFF, ovf 0.
- Hold out_ready = 0 for 5 cycles while offering 3 words -> exactly 2 accepted and in_ready low; on release all 3 emerge in order, one per cycle; assert rst mid-stall -> out_valid 0 the next cycle and nothing stale emerges.
- Macro defined: 3 overflowing handshakes -> ovf_count = 3; ovf_clear together with a 4th overflowing handshake -> 0; with CNT_W = 2 and 5 overflows -> 3. Macro undefined: ovf_count stays 0 throughout.
